// File: rtl/gfx256_pixel_writer.sv
// gfx256_pixel_writer
//
// Converts single pixel write requests (x, y, colour, depth) into 256-bit,
// line-aligned bus writes. Depths of 8, 16 and 32 bpp use a plain byte-enabled
// write. Depths of 1, 2 and 4 bpp read the line first, merge the pixel into
// it and write back the whole line.
//
// Optional build macro: GFX_WRITE_MERGE_EN
//   Adds a valid/tag pair to the line buffer. A sub-byte write that hits the
//   buffered line skips the READ cycle. Byte-wide writes to the buffered line
//   are merged into the buffer so that it stays coherent with memory.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake (one request per transaction)
//   x_i, y_i, width_i     pixel position and target width in pixels
//   color_i, cbpp_i       LSB-aligned colour, bits per pixel (1,2,4,8,16,32)
//   base_i                target base byte address (bits [4:0] ignored)
//   err_o                 one-cycle pulse when a request had an illegal depth
//   cyc_o, stb_o, we_o    bus cycle, strobe and write enable
//   adr_o, sel_o, dat_o   line address, byte selects, write data
//   dat_i, ack_i          bus read data and acknowledge
module gfx256_pixel_writer #(
  parameter int XY_W  = 16,
  parameter int ADR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [XY_W-1:0]    x_i,
  input  logic [XY_W-1:0]    y_i,
  input  logic [31:0]        color_i,
  input  logic [5:0]         cbpp_i,
  input  logic [XY_W-1:0]    width_i,
  input  logic [ADR_W-1:0]   base_i,
  output logic               err_o,
  output logic               cyc_o,
  output logic               stb_o,
  output logic               we_o,
  output logic [ADR_W-1:0]   adr_o,
  output logic [31:0]        sel_o,
  output logic [255:0]       dat_o,
  input  logic [255:0]       dat_i,
  input  logic               ack_i
);

  typedef enum logic [1:0] {IDLE, CALC, READ, WRITE} state_t;

  state_t              state;
  logic [XY_W-1:0]     x_q, y_q, width_q;
  logic [31:0]         color_q;
  logic [5:0]          cbpp_q;
  logic [ADR_W-1:0]    base_q;
  logic [255:0]        field_q;   // new pixel bits at their line position
  logic [255:0]        fmask_q;   // ones over the pixel field

`ifdef GFX_WRITE_MERGE_EN
  logic [255:0]        line_buf;
  logic [ADR_W-1:0]    buf_tag;
  logic                buf_valid;
`endif

  function automatic logic depth_legal(input logic [5:0] c);
    return (c == 6'd1) || (c == 6'd2) || (c == 6'd4) ||
           (c == 6'd8) || (c == 6'd16) || (c == 6'd32);
  endfunction

  function automatic logic [2:0] depth_log2(input logic [5:0] c);
    logic [2:0] r;
    case (c)
      6'd2:    r = 3'd1;
      6'd4:    r = 3'd2;
      6'd8:    r = 3'd3;
      6'd16:   r = 3'd4;
      6'd32:   r = 3'd5;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Address/offset arithmetic for the captured request, used in CALC.
  logic [2*XY_W-1:0]   pix;
  logic [2*XY_W+4:0]   bitaddr;
  logic [2*XY_W-4:0]   line;
  logic [7:0]          mb;
  logic [31:0]         mask;
  logic [255:0]        field, fmask;
  logic [ADR_W-1:0]    calc_adr;
  logic [31:0]         calc_sel;
  logic                calc_rmw;
  logic [255:0]        read_merged;

  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every path, so no latch can be inferred; clocked state uses '<='.
  always_comb begin
    pix         = (2*XY_W)'(y_q) * (2*XY_W)'(width_q) + (2*XY_W)'(x_q);
    bitaddr     = (2*XY_W+5)'(pix) << depth_log2(cbpp_q);
    line        = bitaddr[2*XY_W+4:8];
    mb          = bitaddr[7:0];
    mask        = 32'hFFFF_FFFF >> (6'd32 - cbpp_q);
    field       = 256'(color_q & mask) << mb;
    fmask       = 256'(mask) << mb;
    // base_q has its low five bits cleared at capture, so the sum is
    // always line aligned and wraps at ADR_W bits.
    calc_adr    = base_q + ADR_W'({line, 5'b0});
    calc_sel    = ((32'd1 << cbpp_q[5:3]) - 32'd1) << mb[7:3];
    calc_rmw    = (cbpp_q < 6'd8);
    read_merged = field_q | (dat_i & ~fmask_q);
  end

  // NOTE: only control state and bus outputs are reset; the request capture
  // registers and the line buffer are plain data and are always written
  // before they are used.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      err_o       <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      sel_o       <= '0;
      dat_o       <= '0;
`ifdef GFX_WRITE_MERGE_EN
      buf_valid   <= 1'b0;
`endif
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (depth_legal(cbpp_i)) begin
              x_q         <= x_i;
              y_q         <= y_i;
              width_q     <= width_i;
              color_q     <= color_i;
              cbpp_q      <= cbpp_i;
              base_q      <= base_i & ~ADR_W'(31);
              req_ready_o <= 1'b0;
              state       <= CALC;
            end else begin
              err_o <= 1'b1;
            end
          end
        end

        CALC: begin
          field_q <= field;
          fmask_q <= fmask;
          adr_o   <= calc_adr;
          cyc_o   <= 1'b1;
          stb_o   <= 1'b1;
          if (calc_rmw) begin
            sel_o <= '1;
`ifdef GFX_WRITE_MERGE_EN
            if (buf_valid && (buf_tag == calc_adr)) begin
              // Buffered line is current: merge without reading memory.
              we_o     <= 1'b1;
              dat_o    <= field | (line_buf & ~fmask);
              line_buf <= field | (line_buf & ~fmask);
              state    <= WRITE;
            end else begin
              we_o  <= 1'b0;
              state <= READ;
            end
`else
            we_o  <= 1'b0;
            state <= READ;
`endif
          end else begin
            we_o  <= 1'b1;
            sel_o <= calc_sel;
            dat_o <= field;
            state <= WRITE;
`ifdef GFX_WRITE_MERGE_EN
            // Keep the buffer coherent with byte writes to the same line.
            if (buf_valid && (buf_tag == calc_adr))
              line_buf <= (line_buf & ~fmask) | field;
`endif
          end
        end

        READ: begin
          if (ack_i) begin
            // Strobe stays up; the write follows with the merged line.
            we_o  <= 1'b1;
            dat_o <= read_merged;
            state <= WRITE;
`ifdef GFX_WRITE_MERGE_EN
            line_buf  <= read_merged;
            buf_tag   <= adr_o;
            buf_valid <= 1'b1;
`endif
          end
        end

        WRITE: begin
          if (ack_i) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfx256_pixel_writer.sv
// Testbench for gfx256_pixel_writer: randomized and directed pixel writes
// against a plain-arithmetic reference model. Expected bus transactions are
// queued at issue time and compared by an independent bus monitor.
module tb_gfx256_pixel_writer;

`ifdef GFX_WRITE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic         clk, rst;
  logic         req_valid, req_ready;
  logic [15:0]  x, y, width;
  logic [31:0]  color;
  logic [5:0]   cbpp;
  logic [31:0]  base;
  logic         err, cyc, stb, we;
  logic [31:0]  adr, sel;
  logic [255:0] dat_w, dat_r;
  logic         ack;

  gfx256_pixel_writer #(.XY_W(16), .ADR_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .x_i(x), .y_i(y), .color_i(color), .cbpp_i(cbpp),
    .width_i(width), .base_i(base), .err_o(err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel),
    .dat_o(dat_w), .dat_i(dat_r), .ack_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           we;
    logic [31:0]  adr;
    logic [31:0]  sel;
    logic [255:0] dat;
  } txn_t;

  txn_t         exp_q[$];
  logic [255:0] mem     [logic [31:0]];   // what the bus slave holds
  logic [255:0] ref_mem [logic [31:0]];   // what memory should hold
  int           checks = 0;
  int           errors = 0;
  bit           hold_write = 1'b0;
  int           wait_cnt = 0;
  bit           cache_valid = 1'b0;
  logic [31:0]  cache_adr = '0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] line_init(input logic [31:0] a);
    logic [255:0] v;
    for (int i = 0; i < 8; i++)
      v[i*32 +: 32] = (a * (32'(i) * 2 + 3)) ^ 32'hC3A5_96E1 ^ 32'(i);
    return v;
  endfunction

  function automatic logic [255:0] slave_line(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : line_init(a);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : line_init(a);
  endfunction

  function automatic bit is_legal(input logic [5:0] c);
    return c inside {6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};
  endfunction

  // Reference model: pixel index times depth gives a bit position in the
  // target; divide into line and offset and update a line-granular memory.
  task automatic model_request(input logic [15:0] px, py, pw,
                               input logic [31:0] pcol, input logic [5:0] pd,
                               input logic [31:0] pbase, output bit first_we);
    longint unsigned pix, bitpos;
    logic [31:0]     ladr, s;
    int              off;
    logic [255:0]    l, w;
    pix    = 64'(py) * 64'(pw) + 64'(px);
    bitpos = pix * 64'(pd);
    ladr   = 32'(64'(pbase & 32'hFFFF_FFE0) + (bitpos / 256) * 32);
    off    = int'(bitpos % 256);
    l      = ref_line(ladr);
    for (int b = 0; b < int'(pd); b++) l[off + b] = pcol[b];
    ref_mem[ladr] = l;
    if (pd < 6'd8) begin
      if (MERGE && cache_valid && cache_adr == ladr) begin
        first_we = 1'b1;
      end else begin
        first_we = 1'b0;
        exp_q.push_back('{1'b0, ladr, 32'hFFFF_FFFF, '0});
      end
      exp_q.push_back('{1'b1, ladr, 32'hFFFF_FFFF, l});
      cache_valid = 1'b1;
      cache_adr   = ladr;
    end else begin
      first_we = 1'b1;
      w = '0;
      s = '0;
      for (int b = 0; b < int'(pd); b++) w[off + b] = pcol[b];
      for (int k = 0; k < int'(pd) / 8; k++) s[off / 8 + k] = 1'b1;
      exp_q.push_back('{1'b1, ladr, s, w});
    end
  endtask

  // Bus slave: acknowledges after a random delay, updates memory on writes.
  always @(posedge clk) begin
    logic [255:0] bm;
    #1;
    if (rst || !(cyc && stb)) begin
      ack = 1'b0;
    end else if (ack) begin
      ack = 1'b0;
    end else if (we && hold_write) begin
      ack = 1'b0;
    end else if (wait_cnt > 0) begin
      wait_cnt--;
    end else begin
      ack = 1'b1;
      if (we) begin
        for (int k = 0; k < 32; k++) bm[k*8 +: 8] = {8{sel[k]}};
        mem[adr] = (slave_line(adr) & ~bm) | (dat_w & bm);
      end else begin
        dat_r = slave_line(adr);
      end
      wait_cnt = $urandom_range(0, 3);
    end
  end

  // Monitor: every completed bus cycle is matched against the queue.
  always @(negedge clk) begin
    txn_t t;
    if (!rst && cyc && stb && ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bus_cycle: got adr=%0h we=%0b expected none",
                 adr, we);
      end else begin
        t = exp_q.pop_front();
        check("bus_we", 256'(we), 256'(t.we));
        check("bus_adr", 256'(adr), 256'(t.adr));
        check("bus_sel", 256'(sel), 256'(t.sel));
        if (t.we) check("bus_dat", dat_w, t.dat);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 256'(req_ready), 256'(1));
  endtask

  task automatic send(input logic [15:0] px, py, pw, input logic [31:0] pcol,
                      input logic [5:0] pd, input logic [31:0] pbase,
                      input bit wait_done, output logic [31:0] a_seen,
                      output logic [31:0] s_seen, output logic [255:0] d_seen);
    bit fw;
    wait_ready("ready_before_req");
    model_request(px, py, pw, pcol, pd, pbase, fw);
    x = px; y = py; width = pw; color = pcol; cbpp = pd; base = pbase;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("calc_stb_low", 256'(stb), 256'(0));
    check("calc_ready_low", 256'(req_ready), 256'(0));
    @(negedge clk);
    check("strobe_at_t2", 256'(stb), 256'(1));
    check("we_at_t2", 256'(we), 256'(fw));
    a_seen = adr;
    s_seen = sel;
    d_seen = dat_w;
    if (wait_done) wait_ready("ready_after_ack");
  endtask

  task automatic send_illegal(input logic [5:0] pd);
    wait_ready("ready_before_illegal");
    x = 16'($urandom); y = 16'($urandom); width = 16'($urandom);
    color = $urandom; base = $urandom; cbpp = pd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("illegal_err_pulse", 256'(err), 256'(1));
    check("illegal_ready_high", 256'(req_ready), 256'(1));
    check("illegal_no_cyc", 256'(cyc), 256'(0));
    @(negedge clk);
    check("illegal_err_one_cycle", 256'(err), 256'(0));
    check("illegal_still_no_cyc", 256'(cyc), 256'(0));
  endtask

  initial begin
    logic [31:0]  a, s;
    logic [255:0] d, snap;
    logic [5:0]   depths [6];
    logic [5:0]   c;
    int           n;
    depths = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};
    rst = 1'b1; req_valid = 1'b0; ack = 1'b0; dat_r = '0;
    x = '0; y = '0; width = '0; color = '0; cbpp = '0; base = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 256'(req_ready), 256'(1));
    check("rst_err", 256'(err), 256'(0));
    check("rst_cyc", 256'(cyc), 256'(0));
    check("rst_stb", 256'(stb), 256'(0));
    check("rst_we", 256'(we), 256'(0));
    check("rst_adr", 256'(adr), 256'(0));
    check("rst_sel", 256'(sel), 256'(0));
    check("rst_dat", dat_w, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // 32 bpp: pix 643, bit 20576 -> line 80, byte offset 12.
    send(16'd3, 16'd1, 16'd640, 32'hAABBCCDD, 6'd32, 32'h1000, 1'b1, a, s, d);
    check("bpp32_adr", 256'(a), 256'(32'h1A00));
    check("bpp32_sel", 256'(s), 256'(32'h0000_F000));
    check("bpp32_dat", 256'(d[127:96]), 256'(32'hAABBCCDD));

    // 8 bpp: pix 33 -> line 1, byte 1; colour bits above 8 dropped.
    send(16'd33, 16'd0, 16'd64, 32'h1FF, 6'd8, 32'h0, 1'b1, a, s, d);
    check("bpp8_adr", 256'(a), 256'(32'h20));
    check("bpp8_sel", 256'(s), 256'(32'h2));
    check("bpp8_dat", 256'(d[31:0]), 256'(32'h0000_FF00));

    // 1 bpp read-modify-write on an all-zero line.
    mem[32'h0] = '0;
    ref_mem[32'h0] = '0;
    send(16'd5, 16'd0, 16'd256, 32'h1, 6'd1, 32'h0, 1'b1, a, s, d);
    check("bpp1_read_adr", 256'(a), 256'(0));
    check("bpp1_mem", mem[32'h0], 256'(1) << 5);

    // 4 bpp back-to-back into the same byte.
    mem[32'h4000] = '0;
    ref_mem[32'h4000] = '0;
    send(16'd0, 16'd0, 16'd100, 32'hA, 6'd4, 32'h4000, 1'b1, a, s, d);
    send(16'd1, 16'd0, 16'd100, 32'h5, 6'd4, 32'h4000, 1'b1, a, s, d);
    check("b2b_mem_byte", 256'(mem[32'h4000][7:0]), 256'(8'h5A));

    send_illegal(6'd24);
    send_illegal(6'd0);
    send_illegal(6'd63);

    // Reset while the write of an rmw request is held without ack.
    snap = ref_line(32'h8000);
    hold_write = 1'b1;
    send(16'd2, 16'd0, 16'd64, 32'h3, 6'd2, 32'h8000, 1'b0, a, s, d);
    n = 0;
    while (!(stb === 1'b1 && we === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("held_write_reached", 256'(we), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cyc", 256'(cyc), 256'(0));
    check("midrst_stb", 256'(stb), 256'(0));
    check("midrst_ready", 256'(req_ready), 256'(1));
    rst = 1'b0;
    hold_write = 1'b0;
    check("midrst_pending", 256'(exp_q.size()), 256'(1));
    exp_q.delete();
    ref_mem[32'h8000] = snap;
    cache_valid = 1'b0;
    @(negedge clk);
    send(16'd2, 16'd0, 16'd64, 32'h3, 6'd2, 32'h8000, 1'b1, a, s, d);
    check("post_rst_reads", 256'(a), 256'(32'h8000));

    // Random traffic: a mix of line-local and fully random requests.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        do c = 6'($urandom_range(0, 63)); while (is_legal(c));
        send_illegal(c);
      end else if ($urandom_range(0, 1) == 1) begin
        send(16'($urandom_range(0, 63)), 16'($urandom_range(0, 2)), 16'd64,
             $urandom, depths[$urandom_range(0, 5)],
             ($urandom_range(0, 1) == 1) ? 32'h2_0000 : 32'h2_0107,
             1'b1, a, s, d);
      end else begin
        send(16'($urandom), 16'($urandom), 16'($urandom), $urandom,
             depths[$urandom_range(0, 5)], $urandom, 1'b1, a, s, d);
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
